sw_out_arb: RTL
===============

// Module: sw_out_arb
// PURPOSE
//  Round-robin output-port arbiter for the 4-port packet switch. One instance per output port.
//  Shares that output between the 4 input ports at packet granularity.
//  Grant is taken on a head flit (type 10) and held through the matching tail flit (type 11).
//  Flit format: PKTW+1 bits; [PKTW:PKTW-1] type (00 idle, 10 head, 01 body, 11 tail), head [1:0] = dest port.
//  A watchdog force-releases a lock whose tail never arrives.
// PARAMETERS
//  NPORT   4   number of requesting input ports; the RTL supports only 4
//  SELW    2   width of sel, log2(NPORT)
//  MAXLEN  16  maximum cycles a grant may be held before a forced release; >=2
//  CNTW    5   watchdog counter width; must hold MAXLEN-1
// PORTS
//  clk      in   1      clock, rising edge
//  rst      in   1      asynchronous reset, active-low
//  req      in   NPORT  req[i]=1: input i presents a head flit addressed to this output
//  tail     in   NPORT  tail[i]=1: input i presents its tail flit this cycle
//  grant    out  NPORT  one-hot grant to the input port owning this output; 0 when free
//  sel      out  SELW   index of the granted input, drives the output mux; holds last value when free
//  busy     out  1      1 while a grant is held (== |grant)
//  timeout  out  1      one-cycle pulse on a watchdog forced release
// BEHAVIOUR
//  Reset (rst=0, async): grant=0, sel=0, busy=0, timeout=0, ptr=0, cnt=0, state=IDLE. Takes effect immediately.
//   Reset mid-packet drops the lock with no tail required.
//  All outputs are registered. ptr (internal, SELW bits) is the highest-priority input for the next arbitration.
//  State IDLE:
//   - If req!=0 at a rising edge, grant the first set req[i] scanning ptr, ptr+1, ... mod 4.
//   - Next state LOCK; grant=onehot(i), sel=i, busy=1, cnt=0. Latency is 1 cycle from req to grant.
//   - If req==0, stay IDLE with outputs 0 (sel holds).
//  State LOCK (owner = sel):
//   - req is ignored, including deassertion and other requesters. The grant does not change.
//   - tail[sel]=1 at an edge: release. grant=0, busy=0, ptr=sel+1 mod 4, go to IDLE.
//   - tail[j] for j!=sel is ignored.
//   - tail[sel]=0 and cnt==MAXLEN-1: forced release. grant=0, busy=0, ptr=sel+1 mod 4, timeout=1 for one cycle, go to IDLE.
//   - Otherwise cnt=cnt+1. cnt never wraps.
//   - tail[sel]=1 on the expiry cycle is a normal release; timeout stays 0.
//   - Grant is held at most MAXLEN cycles.
//  After any release, at least one cycle has grant=0. Re-arbitration happens at the edge after release, using the new ptr.
//   This gives 1 idle cycle between back-to-back packets.
//  A req on the same edge as a release is not granted on that edge. It is sampled again in IDLE.
//  Fairness: with all 4 requesting continuously, grants rotate 0,1,2,3,0... No input waits more than 3 packets.
//  timeout is 0 in every cycle except the one after a forced release.
//  grant is always one-hot or zero. busy==|grant at all times.
// TESTING
//  T1 reset release, req=0001: grant=0001, sel=0, busy=1 after 1 edge.
//     tail=0001 two cycles later: grant=0000 next edge, ptr=1.
//  T2 req=1111 held, each owner pulses tail one cycle after grant (2-flit packets):
//     grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
//  T3 after a packet from input 1 (ptr=2), req=0011: grant=0001 (order 2,3,0,1). req=1001 then: grant=1000.
//  T4 input 2 locked, tail=1011 (owner bit clear), then req=0000: grant stays 0100.
//     tail=0100: release. Lock is unaffected by req drop.
//  T5 input 1 locked, tail never asserted, MAXLEN=16: grant=0010 for exactly 16 cycles.
//     Then grant=0000, timeout=1 for 1 cycle, ptr=2.
//     Variant: tail[1] on the 16th cycle releases with timeout=0.
//  T6 input 3 locked mid-packet, rst=0 between clock edges: grant=0, busy=0 immediately.
//     After rst=1 with req=1010: grant=0010 (ptr back to 0).

Source files
------------

// File: rtl/sw_out_arb_if.sv
// Handshake bundle between the input ports and one output-port arbiter of the 4-port switch.
// master = requesting input side, slave = the arbiter itself.
interface sw_out_arb_if #(
  parameter int NPORT = 4,
  parameter int SELW  = 2
);
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] tail;
  logic [NPORT-1:0] grant;
  logic [SELW-1:0]  sel;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    output tail,
    input  grant,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  tail,
    output grant,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/sw_out_arb.sv
// Packet-granular round-robin arbiter for one switch output port, with a watchdog that
// force-releases a lock whose tail flit never shows up.
module sw_out_arb #(
  parameter int NPORT  = 4,
  parameter int SELW   = 2,
  parameter int MAXLEN = 16,
  parameter int CNTW   = 5
) (
  input  logic         clk,
  input  logic         rst,
  sw_out_arb_if.slave  arb
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic [SELW-1:0]  sel_q,   sel_d;
  logic             busy_q,  busy_d;
  logic             timeout_q, timeout_d;
  logic [SELW-1:0]  ptr_q,   ptr_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;

  logic [NPORT-1:0] req_rot;
  logic [SELW-1:0]  pick_off;
  logic [SELW-1:0]  pick_idx;
  logic [NPORT-1:0] pick_onehot;

  // Rotate requests so that position 0 is the current highest-priority input; the
  // SELW-bit add wraps modulo NPORT because NPORT is a power of two.
  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_rot
      assign req_rot[gi] = arb.req[ptr_q + SELW'(gi)];
    end
  endgenerate

  always_comb begin
    pick_off = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_off = SELW'(k);
      end
    end
  end

  assign pick_idx = ptr_q + pick_off;

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == SELW'(gi));
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (|arb.req) begin
          grant_d = pick_onehot;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOCK;
        end
      end

      ST_LOCK: begin
        // Only the owner's tail matters; a tail on the expiry cycle wins over the watchdog.
        if (arb.tail[sel_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + SELW'(1);
          state_d = ST_IDLE;
        end else if (cnt_q == CNTW'(MAXLEN - 1)) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = sel_q + SELW'(1);
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign arb.grant   = grant_q;
  assign arb.sel     = sel_q;
  assign arb.busy    = busy_q;
  assign arb.timeout = timeout_q;

endmodule
